input_sram_loader: RTL and testbench



---
 rtl/input_sram_loader_pkg.sv | 22 ++
 rtl/input_sram_loader_col_mask_gen.sv | 14 +
 rtl/input_sram_loader.sv | 155 +++++++++++++++
 tb/tb_input_sram_loader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_sram_loader_pkg.sv
// rtl/input_sram_loader_pkg.sv - shared constants, state encoding and header range check for the input SRAM loader
package input_sram_loader_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] END_MARKER = 16'h00FF;
  localparam int DEF_MIN_DIM = 3;
  localparam int DEF_MAX_DIM = 16;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE,
    HDR_R,
    HDR_C,
    DATA,
    TERM,
    ERR
  } state_t;

  function automatic logic dim_ok(input logic [DATA_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction
endpackage

// File: rtl/input_sram_loader_col_mask_gen.sv
// rtl/input_sram_loader_col_mask_gen.sv - column count to pixel mask (bits [C-1:0] set)
module col_mask_gen
  import input_sram_loader_pkg::*;
(
  input  logic [4:0]        cols,
  output logic [DATA_W-1:0] mask
);
  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      mask[i] = (5'(i) < cols);
    end
  end
endmodule

// File: rtl/input_sram_loader.sv
// rtl/input_sram_loader.sv - streams matrix images into the input SRAM and closes each job with the end marker
module input_sram_loader
  import input_sram_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 12'h000,
  parameter int                MIN_DIM   = DEF_MIN_DIM,
  parameter int                MAX_DIM   = DEF_MAX_DIM
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_final,
  output logic              in_ready,
  output logic              loader_busy,
  output logic              loader_done,
  output logic              loader_error,
  output logic [ADDR_W-1:0] loader_sram_write_address,
  output logic [DATA_W-1:0] loader_sram_write_data,
  output logic              loader_sram_write_enable
);
  state_t state, state_n;

  logic [ADDR_W-1:0] wr_ptr, wr_ptr_n, addr_n;
  logic [4:0]        rows_q, rows_n, cols_q, cols_n, row_cnt, row_cnt_n;
  logic [DATA_W-1:0] data_n, col_mask, wr_word;
  logic              we_n, busy_n, done_n, error_n, wr_req, accept, at_last_addr;

  col_mask_gen u_col_mask (
    .cols (cols_q),
    .mask (col_mask)
  );

  assign in_ready     = (state == HDR_R) || (state == HDR_C) || (state == DATA);
  assign accept       = in_valid & in_ready;
  assign at_last_addr = (wr_ptr == LAST_ADDR);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    wr_ptr_n  = wr_ptr;
    rows_n    = rows_q;
    cols_n    = cols_q;
    row_cnt_n = row_cnt;
    addr_n    = loader_sram_write_address;
    data_n    = loader_sram_write_data;
    we_n      = 1'b0;
    busy_n    = loader_busy;
    done_n    = 1'b0;
    error_n   = loader_error;
    wr_req    = 1'b0;
    wr_word   = '0;

    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (load_start) begin
          state_n  = HDR_R;
          wr_ptr_n = BASE_ADDR;
          error_n  = 1'b0;
          busy_n   = 1'b1;
        end
      end
      HDR_R: begin
        if (accept) begin
          if (at_last_addr) begin
            state_n = ERR;
          end else begin
            wr_req    = 1'b1;
            wr_word   = in_data;
            rows_n    = in_data[4:0];
            row_cnt_n = '0;
            state_n   = dim_ok(in_data, MIN_DIM, MAX_DIM) ? HDR_C : ERR;
          end
        end
      end
      HDR_C: begin
        if (accept) begin
          if (at_last_addr) begin
            state_n = ERR;
          end else begin
            wr_req  = 1'b1;
            wr_word = in_data;
            cols_n  = in_data[4:0];
            state_n = dim_ok(in_data, MIN_DIM, MAX_DIM) ? DATA : ERR;
          end
        end
      end
      DATA: begin
        if (accept) begin
          if (at_last_addr) begin
            state_n = ERR;
          end else begin
            wr_req    = 1'b1;
            wr_word   = in_data & col_mask;
            row_cnt_n = row_cnt + 5'd1;
            if (row_cnt == rows_q - 5'd1) state_n = in_final ? TERM : HDR_R;
            else if (in_final)            state_n = ERR;
          end
        end
      end
      TERM: begin
        // marker may land on the reserved last address; no handshake needed
        wr_req  = 1'b1;
        wr_word = END_MARKER;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      ERR: begin
        error_n = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (wr_req) begin
      we_n     = 1'b1;
      addr_n   = wr_ptr;
      data_n   = wr_word;
      wr_ptr_n = wr_ptr + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr                    <= '0;
      rows_q                    <= '0;
      cols_q                    <= '0;
      row_cnt                   <= '0;
      loader_sram_write_address <= '0;
      loader_sram_write_data    <= '0;
      loader_sram_write_enable  <= 1'b0;
      loader_busy               <= 1'b0;
      loader_done               <= 1'b0;
      loader_error              <= 1'b0;
    end else begin
      wr_ptr                    <= wr_ptr_n;
      rows_q                    <= rows_n;
      cols_q                    <= cols_n;
      row_cnt                   <= row_cnt_n;
      loader_sram_write_address <= addr_n;
      loader_sram_write_data    <= data_n;
      loader_sram_write_enable  <= we_n;
      loader_busy               <= busy_n;
      loader_done               <= done_n;
      loader_error              <= error_n;
    end
  end
endmodule

// File: tb/tb_input_sram_loader.sv
// tb/tb_input_sram_loader.sv - self-checking bench for input_sram_loader
module tb_input_sram_loader;
  logic        clk = 1'b0;
  logic        reset_b, start_lo, start_hi, in_valid, in_final;
  logic [15:0] in_data;

  logic        ready_lo, busy_lo, done_lo, error_lo, we_lo;
  logic [11:0] addr_lo;
  logic [15:0] data_lo;
  logic        ready_hi, busy_hi, done_hi, error_hi, we_hi;
  logic [11:0] addr_hi;
  logic [15:0] data_hi;

  bit          sel;
  logic        obs_ready, obs_busy, obs_done, obs_error, obs_we;
  logic [11:0] obs_addr;
  logic [15:0] obs_data;

  always #5 clk = ~clk;

  input_sram_loader #(.BASE_ADDR(12'h000)) u_lo (
    .clk (clk), .reset_b (reset_b), .load_start (start_lo), .in_valid (in_valid),
    .in_data (in_data), .in_final (in_final), .in_ready (ready_lo),
    .loader_busy (busy_lo), .loader_done (done_lo), .loader_error (error_lo),
    .loader_sram_write_address (addr_lo), .loader_sram_write_data (data_lo),
    .loader_sram_write_enable (we_lo)
  );

  input_sram_loader #(.BASE_ADDR(12'hFF0)) u_hi (
    .clk (clk), .reset_b (reset_b), .load_start (start_hi), .in_valid (in_valid),
    .in_data (in_data), .in_final (in_final), .in_ready (ready_hi),
    .loader_busy (busy_hi), .loader_done (done_hi), .loader_error (error_hi),
    .loader_sram_write_address (addr_hi), .loader_sram_write_data (data_hi),
    .loader_sram_write_enable (we_hi)
  );

  assign obs_ready = sel ? ready_hi : ready_lo;
  assign obs_busy  = sel ? busy_hi  : busy_lo;
  assign obs_done  = sel ? done_hi  : done_lo;
  assign obs_error = sel ? error_hi : error_lo;
  assign obs_we    = sel ? we_hi    : we_lo;
  assign obs_addr  = sel ? addr_hi  : addr_lo;
  assign obs_data  = sel ? data_hi  : data_lo;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // stimulus and reference image
  logic [15:0] beat_d[$];
  bit          beat_f[$];
  logic [27:0] exp_q[$];
  int          exp_nacc, exp_done, exp_err;
  logic [15:0] mem [0:4095];

  // Walks the matrix image rules directly over the beat list.
  task automatic model_job(input int base);
    int i = 0;
    int addr = base;
    int r = 0;
    int c = 0;
    bit stop = 0;
    exp_q.delete();
    exp_done = 0;
    exp_err = 0;
    while (!stop && i < beat_d.size()) begin
      for (int h = 0; h < 2 && !stop && i < beat_d.size(); h++) begin
        if (addr == 4095) begin
          exp_err = 1; stop = 1; i++;
        end else begin
          exp_q.push_back({12'(addr), beat_d[i]});
          addr++;
          if (h == 0) r = int'(beat_d[i]); else c = int'(beat_d[i]);
          if (beat_d[i] < 16'd3 || beat_d[i] > 16'd16) begin exp_err = 1; stop = 1; end
          i++;
        end
      end
      for (int k = 0; k < r && !stop && i < beat_d.size(); k++) begin
        if (addr == 4095) begin
          exp_err = 1; stop = 1; i++;
        end else begin
          exp_q.push_back({12'(addr), beat_d[i] & 16'((32'd1 << c) - 32'd1)});
          addr++;
          if (k == r - 1) begin
            if (beat_f[i]) begin
              exp_q.push_back({12'(addr), 16'h00FF});
              exp_done = 1; stop = 1;
            end
          end else if (beat_f[i]) begin
            exp_err = 1; stop = 1;
          end
          i++;
        end
      end
    end
    exp_nacc = i;
  endtask

  // per-cycle output observer
  int cyc = 0;
  int done_seen, wr_count, first_we_cyc, last_we_cyc, err_rise_cyc;
  logic prev_done = 1'b0, prev_err = 1'b0;

  always @(negedge clk) begin
    logic [27:0] e;
    cyc++;
    if (reset_b) begin
      if (obs_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {8'h0, obs_addr, obs_data}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(obs_addr), 32'(e[27:16]));
          check("wr_data", 32'(obs_data), 32'(e[15:0]));
        end
        mem[obs_addr] = obs_data;
        if (wr_count == 0) first_we_cyc = cyc;
        last_we_cyc = cyc;
        wr_count++;
      end
      if (obs_done) begin
        done_seen++;
        check("done_with_marker", {15'h0, obs_we, obs_data}, {15'h0, 1'b1, 16'h00FF});
      end
      if (prev_done) check("busy_fall_after_done", 32'(obs_busy), 32'd0);
      if (obs_error && !prev_err) err_rise_cyc = cyc;
      prev_done = obs_done;
      prev_err  = obs_error;
    end else begin
      prev_done = 1'b0;
      prev_err  = 1'b0;
    end
  end

  task automatic run_job(input bit hi, output int stalls);
    int guard;
    model_job(hi ? 12'hFF0 : 12'h000);
    sel = hi;
    done_seen = 0;
    wr_count = 0;
    stalls = 0;
    @(negedge clk);
    if (hi) start_hi = 1'b1; else start_lo = 1'b1;
    @(negedge clk);
    start_hi = 1'b0;
    start_lo = 1'b0;
    check("busy_rise", 32'(obs_busy), 32'd1);
    check("error_clear", 32'(obs_error), 32'd0);
    for (int b = 0; b < exp_nacc; b++) begin
      in_valid = 1'b1;
      in_data  = beat_d[b];
      in_final = beat_f[b];
      guard = 0;
      while (!obs_ready && guard < 50) begin
        @(negedge clk);
        stalls++;
        guard++;
      end
      if (!obs_ready) begin
        check("ready_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_final = 1'b0;
    repeat (4) @(negedge clk);
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_seen), 32'(exp_done));
    check("error_flag", 32'(obs_error), 32'(exp_err));
    check("busy_idle", 32'(obs_busy), 32'd0);
    check("ready_idle", 32'(obs_ready), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 32'(obs_ready), 32'd0);
    check({tag, "_busy"},  32'(obs_busy),  32'd0);
    check({tag, "_done"},  32'(obs_done),  32'd0);
    check({tag, "_error"}, 32'(obs_error), 32'd0);
    check({tag, "_we"},    32'(obs_we),    32'd0);
    check({tag, "_addr"},  32'(obs_addr),  32'd0);
    check({tag, "_data"},  32'(obs_data),  32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int stalls;
    logic [15:0] img1 [6];
    img1 = '{16'd3, 16'd3, 16'h0005, 16'h0002, 16'h0007, 16'h00FF};

    sel = 0; reset_b = 1'b0; start_lo = 0; start_hi = 0;
    in_valid = 0; in_final = 0; in_data = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_b = 1'b1;
    repeat (2) @(negedge clk);

    // single 3x3 matrix
    beat_d = {16'd3, 16'd3, 16'h0005, 16'h0002, 16'h0007};
    beat_f = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    model_job(0);
    for (int i = 0; i < 6; i++) check("model_img1", 32'(exp_q[i][15:0]), 32'(img1[i]));
    run_job(0, stalls);
    for (int i = 0; i < 6; i++) check("mem_img1", 32'(mem[i]), 32'(img1[i]));

    // 4x4 then 16x16, valid held throughout
    beat_d.delete(); beat_f.delete();
    beat_d.push_back(16'd4); beat_f.push_back(0);
    beat_d.push_back(16'd4); beat_f.push_back(0);
    for (int k = 0; k < 4; k++) begin beat_d.push_back(16'hA5A0 + 16'(k)); beat_f.push_back(0); end
    beat_d.push_back(16'd16); beat_f.push_back(0);
    beat_d.push_back(16'd16); beat_f.push_back(0);
    for (int k = 0; k < 16; k++) begin beat_d.push_back(16'h3C00 ^ 16'(k * 77)); beat_f.push_back(k == 15); end
    run_job(0, stalls);
    check("two_mat_stalls", 32'(stalls), 32'd0);
    check("two_mat_writes", 32'(wr_count), 32'd25);
    check("two_mat_contiguous", 32'(last_we_cyc - first_we_cyc + 1), 32'd25);
    check("two_mat_term", 32'(mem[24]), 32'h00FF);
    check("two_mat_hdr2", 32'(mem[6]), 32'd16);
    check("two_mat_row0_mask", 32'(mem[2]), 32'h0000);

    // column masking with C=5
    beat_d = {16'd3, 16'd5, 16'hFFFF, 16'h1234, 16'hFFE0};
    beat_f = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    run_job(0, stalls);
    check("mask_ffff", 32'(mem[2]), 32'h001F);
    check("mask_1234", 32'(mem[3]), 32'h0014);
    check("mask_ffe0", 32'(mem[4]), 32'h0000);

    // illegal R = 0x00FF
    beat_d = {16'h00FF, 16'd3};
    beat_f = {1'b0, 1'b0};
    model_job(0);
    check("model_badr_nacc", 32'(exp_nacc), 32'd1);
    run_job(0, stalls);
    check("badr_err_timing", 32'(err_rise_cyc - last_we_cyc), 32'd1);

    // illegal C = 2
    beat_d = {16'd4, 16'd2, 16'h0001};
    beat_f = {1'b0, 1'b0, 1'b0};
    run_job(0, stalls);
    check("badc_err_timing", 32'(err_rise_cyc - last_we_cyc), 32'd1);
    check("badc_writes", 32'(wr_count), 32'd2);

    // early in_final on row 1 of 3, then a good job
    beat_d = {16'd3, 16'd3, 16'h0001};
    beat_f = {1'b0, 1'b0, 1'b1};
    run_job(0, stalls);
    beat_d = {16'd3, 16'd3, 16'h0005, 16'h0002, 16'h0007};
    beat_f = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    run_job(0, stalls);
    check("recover_term", 32'(mem[5]), 32'h00FF);

    // high base: must stop before writing 0xFFF
    beat_d.delete(); beat_f.delete();
    beat_d.push_back(16'd16); beat_f.push_back(0);
    beat_d.push_back(16'd16); beat_f.push_back(0);
    for (int k = 0; k < 16; k++) begin beat_d.push_back(16'h1000 + 16'(k)); beat_f.push_back(k == 15); end
    model_job(12'hFF0);
    check("model_hi_nacc", 32'(exp_nacc), 32'd16);
    check("model_hi_writes", 32'(exp_q.size()), 32'd15);
    run_job(1, stalls);
    check("hi_last_row", 32'(mem[12'hFFE]), 32'h100C);
    sel = 0;

    // reset mid-DATA
    beat_d = {16'd4, 16'd4, 16'h000F, 16'h00F0, 16'h0F00, 16'hF000};
    beat_f = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    model_job(0);
    done_seen = 0; wr_count = 0;
    @(negedge clk); start_lo = 1'b1;
    @(negedge clk); start_lo = 1'b0;
    in_valid = 1'b1; in_final = 1'b0;
    for (int b = 0; b < 3; b++) begin
      in_data = beat_d[b];
      @(posedge clk);
      #1;
    end
    check("inflight_we", 32'(obs_we), 32'd1);
    check("inflight_addr", 32'(obs_addr), 32'd2);
    #1 reset_b = 1'b0;
    #1 check_outputs_zero("midreset");
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset_b = 1'b1;
    beat_d = {16'd3, 16'd3, 16'h0005, 16'h0002, 16'h0007};
    beat_f = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    run_job(0, stalls);
    for (int i = 0; i < 6; i++) check("post_reset_img", 32'(mem[i]), 32'(img1[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
